modulo_medidor_frequencia: RTL and testbench

- Measures the period and high time of a slow square wave in `clk` cycles.
- Typical input: the output of the frequency divider, or any slow external signal.
- It is the receiving end of the slow-clock interface:
  - the divider generates the slow waveform;
  - this block captures one full cycle of it on request and reports period, high time and overflow.
- Sits beside the divider, used for self-check and for the display/status path.

---
 rtl/modulo_medidor_frequencia_pkg.sv | 14 +
 rtl/modulo_sincronizador_borda.sv | 30 +++
 rtl/modulo_medidor_frequencia.sv | 135 +++++++++++++
 tb/tb_modulo_medidor_frequencia.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/modulo_medidor_frequencia_pkg.sv
// Shared FSM state encoding and default sizes for the period/high-time meter.
package pkg_medidor;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_MEAS = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int CNT_W_DEFAULT = 24;
  localparam int SYNC_DEFAULT  = 2;

endpackage

// File: rtl/modulo_sincronizador_borda.sv
// Brings the asynchronous measured signal into the clk domain and flags its rising edges.
module modulo_sincronizador_borda
  import pkg_medidor::*;
#(
  parameter int SYNC_STAGES = SYNC_DEFAULT
) (
  input  logic clk,
  input  logic clr,
  input  logic sig_in,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_s_d  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign s    = r_sync[SYNC_STAGES-1];
  assign rise = s & ~r_s_d;

endmodule

// File: rtl/modulo_medidor_frequencia.sv
// Captures one period and high time of a slow square wave on request.
// Define MEDIDOR_CONTINUO_EN to keep measuring back-to-back while start is held.
module modulo_medidor_frequencia
  import pkg_medidor::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = SYNC_DEFAULT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] C_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_MAX    = '1;
  localparam logic [CNT_W-1:0] C_MAX_M1 = C_MAX - C_ONE;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_ovf;
  logic             r_valid;
  logic             w_s;
  logic             w_rise;
  logic             w_start_acc;
  logic             w_open;
  logic             w_capture;
  logic             w_saturate;

  modulo_sincronizador_borda #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sinc (
    .clk   (clk),
    .clr   (clr),
    .sig_in(sig_in),
    .s     (w_s),
    .rise  (w_rise)
  );

  // Saturation fires on the cycle the counter would reach all-ones, so it never wraps.
  always_comb begin
    w_next      = r_state;
    w_start_acc = 1'b0;
    w_open      = 1'b0;
    w_capture   = 1'b0;
    w_saturate  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_next      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_rise) begin
          w_open = 1'b1;
          w_next = ST_MEAS;
        end else if (r_cnt == C_MAX_M1) begin
          w_saturate = 1'b1;
          w_next     = ST_DONE;
        end
      end
      ST_MEAS: begin
        if (w_rise) begin
          w_capture = 1'b1;
`ifdef MEDIDOR_CONTINUO_EN
          w_open = 1'b1;
          w_next = start ? ST_MEAS : ST_DONE;
`else
          w_next = ST_DONE;
`endif
        end else if (r_cnt == C_MAX_M1) begin
          w_saturate = 1'b1;
          w_next     = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hcnt   <= '0;
      r_period <= '0;
      r_high   <= '0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= w_capture | w_saturate;

      if (w_start_acc) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_open) begin
        r_cnt  <= C_ONE;
        r_hcnt <= C_ONE;
      end else if (r_state == ST_WAIT || r_state == ST_MEAS) begin
        r_cnt <= r_cnt + C_ONE;
        if (r_state == ST_MEAS && w_s) r_hcnt <= r_hcnt + C_ONE;
      end

      if (w_capture) begin
        r_period <= r_cnt;
        r_high   <= r_hcnt;
      end

      // A timeout while still waiting has seen no high time at all.
      if (w_saturate) begin
        r_period <= C_MAX;
        r_high   <= (r_state == ST_WAIT) ? '0 : r_hcnt;
        r_ovf    <= 1'b1;
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign valid     = r_valid;
  assign period    = r_period;
  assign high_time = r_high;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_modulo_medidor_frequencia.sv
// Directed bench for the period/high-time meter with a timestamp-based reference model.
module tb_modulo_medidor_frequencia;

  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             clr;
  logic             sig_in;
  logic             start;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             overflow;

  int n_checks = 0;
  int n_err    = 0;
  int n_valid  = 0;
  bit chk_on   = 1'b0;

  int gen_hi    = 1;
  int gen_lo    = 1;
  int gen_epoch = 0;
  bit gen_en    = 1'b0;

  modulo_medidor_frequencia #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .sig_in   (sig_in),
    .start    (start),
    .busy     (busy),
    .valid    (valid),
    .period   (period),
    .high_time(high_time),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endfunction

  // Square-wave generator: high gen_hi cycles, low gen_lo cycles, restarted on each new epoch.
  initial begin : gen
    int ph;
    int ep;
    ph = 0;
    ep = 0;
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ep != gen_epoch) begin
        ep = gen_epoch;
        ph = 0;
      end
      if (!gen_en) sig_in = 1'b0;
      else begin
        sig_in = (ph < gen_hi);
        ph = (ph + 1) % (gen_hi + gen_lo);
      end
    end
  end

  // Reference model: timestamps of synchronized rising edges give period and high time directly.
  int m_k = 0;
  int m_mode = 0;       // 0 idle, 1 armed, 2 result cycle
  int m_c = 0;          // edge at which start was accepted
  int m_r1 = -1;        // edge of the opening rise, -1 until it occurs
  int m_hsum = 0;       // synchronized-high edges since the opening rise
  bit hist[$];          // synchronized-domain history, newest first
  bit e_busy = 1'b0, e_valid = 1'b0, e_ovf = 1'b0;
  int e_period = 0, e_high = 0;

  initial begin
    for (int i = 0; i <= SYNC; i++) hist.push_back(1'b0);
  end

  always @(posedge clk) begin : model
    bit s_now;
    bit rise_now;
    if (clr) begin
      m_mode = 0; m_r1 = -1; m_hsum = 0;
      e_busy = 0; e_valid = 0; e_ovf = 0; e_period = 0; e_high = 0;
      for (int i = 0; i <= SYNC; i++) hist[i] = 1'b0;
    end else begin
      s_now    = hist[SYNC-1];
      rise_now = s_now && !hist[SYNC];
      e_valid  = 1'b0;
      case (m_mode)
        0: if (start) begin
          m_mode = 1; m_c = m_k; m_r1 = -1; e_ovf = 1'b0;
        end
        1: begin
          if (m_r1 < 0) begin
            if (rise_now) begin
              m_r1 = m_k; m_hsum = 1;
            end else if (m_k - m_c == MAXV) begin
              e_period = MAXV; e_high = 0; e_ovf = 1'b1; e_valid = 1'b1; m_mode = 2;
            end
          end else begin
            if (rise_now) begin
              e_period = m_k - m_r1; e_high = m_hsum; e_valid = 1'b1;
`ifdef MEDIDOR_CONTINUO_EN
              if (start) begin
                m_r1 = m_k; m_hsum = 1;
              end else m_mode = 2;
`else
              m_mode = 2;
`endif
            end else if (m_k - m_r1 == MAXV - 1) begin
              e_period = MAXV; e_high = m_hsum; e_ovf = 1'b1; e_valid = 1'b1; m_mode = 2;
            end else begin
              m_hsum += int'(s_now);
            end
          end
        end
        default: m_mode = 0;
      endcase
      e_busy = (m_mode != 0);
      hist.push_front(sig_in);
      void'(hist.pop_back());
    end
    m_k++;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_busy", busy, e_busy);
      chk("model_valid", valid, e_valid);
      chk("model_period", period, e_period);
      chk("model_high_time", high_time, e_high);
      chk("model_overflow", overflow, e_ovf);
      if (valid === 1'b1) n_valid++;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic set_gen(input int hi, input int lo);
    gen_hi = hi; gen_lo = lo; gen_epoch++; gen_en = 1'b1;
    repeat (2 * (hi + lo) + 4) @(posedge clk);
  endtask

  task automatic wait_valid(input int lim, input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (valid !== 1'b1 && n < lim);
    chk({name, "_valid_seen"}, valid, 1);
  endtask

  initial begin
    int n;
    int nv0;
    clr = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_period", period, 0);
    chk("rst_overflow", overflow, 0);

    // Symmetric 8/8 waveform.
    set_gen(8, 8);
    pulse_start();
    wait_valid(100, "basic", n);
    chk("basic_period", period, 16);
    chk("basic_high", high_time, 8);
    chk("basic_ovf", overflow, 0);
    @(negedge clk);
    chk("basic_busy_drop", busy, 0);
    chk("basic_valid_pulse", valid, 0);

    // Asymmetric 3/9 waveform.
    set_gen(3, 9);
    pulse_start();
    wait_valid(100, "asym", n);
    chk("asym_period", period, 12);
    chk("asym_high", high_time, 3);

    // Second start while busy is ignored.
    set_gen(5, 5);
    nv0 = n_valid;
    pulse_start();
    repeat (6) @(negedge clk);
    chk("busy_before_2nd_start", busy, 1);
    pulse_start();
    repeat (60) @(negedge clk);
    chk("busy_one_valid", n_valid - nv0, 1);
    chk("busy_period", period, 10);
    chk("busy_high", high_time, 5);

    // Timeout with the input held low.
    gen_en = 1'b0;
    repeat (10) @(posedge clk);
    pulse_start();
    wait_valid(300, "timeout", n);
    chk("timeout_latency", n, 256);
    chk("timeout_period", period, 8'hFF);
    chk("timeout_high", high_time, 0);
    chk("timeout_ovf", overflow, 1);
    @(negedge clk);
    chk("timeout_busy_drop", busy, 0);

    // Clear in the middle of a measurement.
    repeat (4) @(posedge clk);
    pulse_start();
    gen_hi = 20; gen_lo = 20; gen_epoch++; gen_en = 1'b1;
    repeat (15) @(negedge clk);
    chk("clr_busy_before", busy, 1);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_busy", busy, 0);
    chk("clr_period", period, 0);
    chk("clr_overflow", overflow, 0);
    nv0 = n_valid;
    repeat (80) @(negedge clk);
    chk("clr_no_valid", n_valid - nv0, 0);

`ifdef MEDIDOR_CONTINUO_EN
    // Start held: back-to-back captures, then one final capture after release.
    set_gen(5, 5);
    @(posedge clk); #1 start = 1'b1;
    nv0 = 0;
    repeat (60) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        nv0++;
        chk("cont_period", period, 10);
      end
    end
    chk("cont_count_ge4", (nv0 >= 4), 1);
    @(posedge clk); #1 start = 1'b0;
    wait_valid(40, "cont_final", n);
    chk("cont_final_period", period, 10);
    @(negedge clk);
    chk("cont_idle", busy, 0);
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
